// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the hazard sequencer and its neighbours.
//   hz_state_t  : sequencer FSM states
//   REG_X0      : architectural zero register index
//   stage_ctl_t : per-stage stall/flush bundle
//   src_match() : true when an ID source operand is live and names rd
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        RECOVER  = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } stage_ctl_t;

    function automatic logic src_match(input logic uses, input logic [4:0] rs,
                                       input logic [4:0] rd);
        return uses && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Hazard bus between the pipeline datapath and the hazard sequencer.
//   master : datapath side, drives hazard sources, receives stall/flush
//   slave  : sequencer side, receives hazard sources, drives stall/flush
interface hazard_sequencer_if;
    logic       MemReadE;
    logic [4:0] rdE;
    logic [4:0] rs1_addrD;
    logic [4:0] rs2_addrD;
    logic       uses_rs1D;
    logic       uses_rs2D;
    logic       mispredictE;
    logic       mem_reqM;
    logic       mem_readyM;
    logic       stallF;
    logic       stallD;
    logic       stallE;
    logic       stallM;
    logic       flushD;
    logic       flushE;
    logic       flushW;

    modport master (
        output MemReadE, rdE, rs1_addrD, rs2_addrD, uses_rs1D, uses_rs2D,
        output mispredictE, mem_reqM, mem_readyM,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW
    );

    modport slave (
        input  MemReadE, rdE, rs1_addrD, rs2_addrD, uses_rs1D, uses_rs2D,
        input  mispredictE, mem_reqM, mem_readyM,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance statistics.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : add one this cycle (ignored once at all-ones)
//   clr      : synchronous clear, dominates inc
//   cnt      : current count
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Central stall/flush controller for the 5-stage RV32I pipeline.
//   clk, rst     : pipeline clock, asynchronous active-high reset
//   bus          : hazard sources in, per-stage stall/flush out (slave modport)
//   mem_err      : sticky, a data-memory wait lasted MEM_TIMEOUT cycles
//   stall_cycles : saturating count of cycles with stallF=1
//   flush_events : saturating count of mispredict recoveries started
//
// state    | meaning
// RUN      | normal flow, load-use detection active
// MEM_WAIT | previous cycle stalled on data memory
// RECOVER  | front-end flush still owed after a mispredict
module hazard_sequencer
    import pipeline_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    hazard_sequencer_if.slave bus,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam int RW = 3;

    hz_state_t   state_q, state_d;
    logic [RW-1:0] rem_q, rem_d;
    logic        pend_q, pend_d;
    logic [WW-1:0] wait_q, wait_d;
    logic        err_q, err_d;

    logic        mem_wait;
    logic        rec_start;
    logic        load_use;
    stage_ctl_t  ctl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            rem_q   <= '0;
            pend_q  <= 1'b0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pend_q  <= pend_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        mem_wait  = bus.mem_reqM & ~bus.mem_readyM;
        // A mispredict seen during a memory wait is replayed on the release cycle.
        rec_start = ~mem_wait & (bus.mispredictE | pend_q);
        load_use  = bus.MemReadE && (bus.rdE != REG_X0) &&
                    (src_match(bus.uses_rs1D, bus.rs1_addrD, bus.rdE) ||
                     src_match(bus.uses_rs2D, bus.rs2_addrD, bus.rdE));

        ctl     = '0;
        state_d = state_q;
        rem_d   = rem_q;
        pend_d  = 1'b0;
        wait_d  = '0;
        err_d   = err_q;

        if (mem_wait) begin
            ctl.stall_f = 1'b1;
            ctl.stall_d = 1'b1;
            ctl.stall_e = 1'b1;
            ctl.stall_m = 1'b1;
            ctl.flush_w = 1'b1;
            pend_d      = pend_q | bus.mispredictE;
            wait_d      = (wait_q == WW'(MEM_TIMEOUT)) ? wait_q : wait_q + 1'b1;
            if (wait_q >= WW'(MEM_TIMEOUT - 1)) begin
                err_d = 1'b1;
            end
            state_d = MEM_WAIT;
        end else begin
            // rem counts flush cycles still owed after the current one; a
            // recovery interrupted by a memory wait resumes where it left off.
            if (rec_start) begin
                ctl.flush_d = 1'b1;
                ctl.flush_e = 1'b1;
                rem_d       = RW'(FLUSH_CYCLES - 1);
            end else if (rem_q != '0) begin
                ctl.flush_d = 1'b1;
                ctl.flush_e = 1'b1;
                rem_d       = rem_q - 1'b1;
            end else if ((state_q == RUN) && load_use) begin
                ctl.stall_f = 1'b1;
                ctl.stall_d = 1'b1;
                ctl.flush_e = 1'b1;
            end
            state_d = (rem_d != '0) ? RECOVER : RUN;
        end

        if (rst) begin
            ctl = '0;
        end
    end

    assign bus.stallF = ctl.stall_f;
    assign bus.stallD = ctl.stall_d;
    assign bus.stallE = ctl.stall_e;
    assign bus.stallM = ctl.stall_m;
    assign bus.flushD = ctl.flush_d;
    assign bus.flushE = ctl.flush_e;
    assign bus.flushW = ctl.flush_w;
    assign mem_err    = err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ctl.stall_f),
        .clr (1'b0),
        .cnt (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (rec_start),
        .clr (1'b0),
        .cnt (flush_events)
    );

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Central stall/flush controller for the 5-stage RV32I pipeline. It drives the IF/ID, ID/EX, EX/MEM and MEM/WB register enables and bubble inputs, including the ID/EX stall and flush pins. It resolves load-use hazards, branch/jump mispredict recovery and multi-cycle data-memory waits through a small FSM. It also keeps saturating performance counters and a sticky memory-timeout error flag.

Parameters:
FLUSH_CYCLES, 1, cycles of front-end flush after a mispredict (1..4)
MEM_TIMEOUT, 255, consecutive MEM_WAIT cycles before mem_err is set
CNT_W, 32, width of performance counters

Ports:
clk  in  1  pipeline clock; state and counters update on posedge
rst  in  1  asynchronous, active-high reset
MemReadE  in  1  instruction in EX is a load
rdE  in  5  EX destination register
rs1_addrD  in  5  ID source register 1
rs2_addrD  in  5  ID source register 2
uses_rs1D  in  1  ID instruction reads rs1
uses_rs2D  in  1  ID instruction reads rs2
mispredictE  in  1  EX resolved branch/jump differs from the fetch-time prediction
mem_reqM  in  1  MEM stage issues a data-memory access
mem_readyM  in  1  data memory completes the access this cycle
stallF  out  1  hold PC
stallD  out  1  hold IF/ID
stallE  out  1  hold ID/EX
stallM  out  1  hold EX/MEM
flushD  out  1  bubble IF/ID
flushE  out  1  bubble ID/EX (control bits and rdE zeroed)
flushW  out  1  bubble MEM/WB
mem_err  out  1  sticky: memory wait exceeded MEM_TIMEOUT
stall_cycles  out  CNT_W  count of cycles with stallF=1, saturating
flush_events  out  CNT_W  count of mispredict recoveries started, saturating

Behaviour:
- FSM states: RUN, MEM_WAIT, RECOVER. State is a register; all stall/flush outputs are combinational from state, internal registers and inputs.
- Reset (rst=1, asynchronous): state=RUN, recover count=0, pend_mispredict=0, wait count=0, mem_err=0, both counters=0. While rst=1, all stall/flush outputs are 0.
- Priority: memory wait > mispredict > load-use.
- Memory wait:
  - Condition: mem_reqM=1 and mem_readyM=0, in any state.
  - Outputs that cycle: stallF=stallD=stallE=stallM=1, flushW=1, flushD=flushE=0.
  - Next state=MEM_WAIT. The wait counter increments by 1 per cycle.
  - Exit: the cycle with mem_readyM=1 releases all stalls the same cycle (zero extra latency). The wait counter clears.
  - If the wait counter reaches MEM_TIMEOUT, set mem_err=1 (sticky until rst). Stalling continues regardless.
- Mispredict:
  - Fires when mispredictE=1 and no memory wait is active.
  - Outputs that cycle: flushD=1, flushE=1, no stalls.
  - If FLUSH_CYCLES>1: go to RECOVER with count FLUSH_CYCLES-1. flushD=flushE=1 each RECOVER cycle; return to RUN when count reaches 0.
  - flush_events increments once per recovery, on the cycle the recovery starts.
- Mispredict during memory wait: set pend_mispredict=1. Recovery starts on the mem_readyM=1 cycle, with stalls released and flushes asserted together. pend_mispredict then clears.
- Load-use:
  - Condition: state RUN, no memory wait, no mispredict, MemReadE=1, rdE!=0, and (uses_rs1D and rs1_addrD==rdE, or uses_rs2D and rs2_addrD==rdE).
  - Outputs: stallF=stallD=1, flushE=1 for exactly one cycle. The hazard clears naturally next cycle.
  - Suppressed in RECOVER, because the ID instruction is being discarded.
- Never assert stall and flush on the same pipeline register in the same cycle. A second mispredict during RECOVER restarts the recovery count and increments flush_events.
- Counters saturate at all-ones and never wrap.

Decomposition:
- Shared package pipeline_pkg: enum hz_state_t {RUN, MEM_WAIT, RECOVER} and constant REG_X0=5'd0. The package also holds the stage-control bundle struct (stall/flush per stage), shared with the top level.
- One sub-module, sat_counter (parameter W; inc, clr inputs), instantiated twice for the performance counters.

Test Plan:
- Load-use: lw x5 in EX (MemReadE=1, rdE=5), ID add uses rs1=5 -> one cycle of stallF=stallD=1, flushE=1; stall_cycles=1. Same case with rdE=0 -> no stall.
- Mispredict, FLUSH_CYCLES=1: mispredictE pulse -> flushD=flushE=1 for 1 cycle, flush_events=1. Rerun with FLUSH_CYCLES=3 -> 3 consecutive flush cycles.
- Memory wait: mem_reqM=1, mem_readyM low for 4 cycles -> stallF/D/E/M=1 and flushW=1 for 4 cycles, released on the ready cycle; stall_cycles=4.
- Mispredict during a 3-cycle memory wait -> no flush while stalled; flushD=flushE=1 on the mem_readyM cycle; flush_events=1.
- Timeout, MEM_TIMEOUT=8: 10-cycle wait -> mem_err=1 from cycle 8 and stays 1 after ready; only rst clears it.
- Reset mid-MEM_WAIT: assert rst asynchronously -> all outputs 0, state RUN, counters 0 immediately; load-use still detected after rst deasserts.
